// File: rtl/soundrive_if.sv
// Soundrive scheduler bus: CPU port writes, DMA frame stream, stream control and mixer outputs.
// master = CPU/DMA side that drives the scheduler, slave = soundrive_sched.
interface soundrive_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 12
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             cpu_wr;
  logic [1:0]       cpu_ch;
  logic [7:0]       cpu_data;
  logic             stream_en;
  logic [DIV_W-1:0] rate_div;
  logic             dma_req;
  logic [31:0]      dma_data;
  logic             dma_ack;
  logic [7:0]       sd_l0;
  logic [7:0]       sd_l1;
  logic [7:0]       sd_r0;
  logic [7:0]       sd_r1;
  logic [LVL_W-1:0] fifo_level;
  logic             underrun;
  logic             underrun_clr;

  modport master (
    output cpu_wr, cpu_ch, cpu_data, stream_en, rate_div, dma_req, dma_data, underrun_clr,
    input  dma_ack, sd_l0, sd_l1, sd_r0, sd_r1, fifo_level, underrun
  );

  modport slave (
    input  cpu_wr, cpu_ch, cpu_data, stream_en, rate_div, dma_req, dma_data, underrun_clr,
    output dma_ack, sd_l0, sd_l1, sd_r0, sd_r1, fifo_level, underrun
  );
endinterface

// File: rtl/soundrive_sched.sv
// Soundrive channel-register owner: CPU port writes vs. FIFO-buffered DMA stream at a divided rate.
// Optional SOUNDRIVE_SCHED_MIDSCALE_EN: registers reset/idle/underrun to 8'h80 instead of 0/hold.
//
// state | meaning
// IDLE  | CPU owns sd_*, FIFO flushed, no DMA acks
// PRIME | stream owns sd_*, FIFO filling, no playback
// PLAY  | divider ticks pop one frame per sample period
module soundrive_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 12
) (
  input logic         clk28,
  input logic         rst_n,
  soundrive_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef SOUNDRIVE_SCHED_MIDSCALE_EN
  localparam logic [7:0] SD_RST = 8'h80;
`else
  localparam logic [7:0] SD_RST = 8'h00;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_PLAY} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_sd_l0, r_sd_l1, r_sd_r0, r_sd_r1;
  logic             r_underrun;
  logic             w_full, w_empty, w_tick, w_push, w_pop, w_urun, w_div_load;
  logic [31:0]      w_head;

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_tick  = (r_div == '0);
  assign w_push  = bus.dma_req && !w_full && (r_state != ST_IDLE);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_urun      = 1'b0;
    w_div_load  = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.stream_en) w_state_nxt = ST_PRIME;
      ST_PRIME: if (r_level >= LVL_W'(FIFO_DEPTH / 2)) begin
        w_state_nxt = ST_PLAY;
        w_div_load  = 1'b1;
      end
      ST_PLAY: if (w_tick) begin
        if (w_empty) begin
          w_urun      = 1'b1;
          w_state_nxt = ST_PRIME;
        end else begin
          w_pop = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!bus.stream_en) w_state_nxt = ST_IDLE;
  end

  // A rate_div change is only picked up at a reload, never mid-count.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)                 r_div <= '0;
    else if (w_div_load)        r_div <= bus.rate_div;
    else if (r_state == ST_PLAY) r_div <= w_tick ? bus.rate_div : r_div - DIV_W'(1);
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (r_state == ST_IDLE) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset: contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk28) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.dma_data;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_sd_l0 <= SD_RST;
      r_sd_l1 <= SD_RST;
      r_sd_r0 <= SD_RST;
      r_sd_r1 <= SD_RST;
`ifdef SOUNDRIVE_SCHED_MIDSCALE_EN
    end else if ((r_state != ST_IDLE && w_state_nxt == ST_IDLE) || w_urun) begin
      r_sd_l0 <= SD_RST;
      r_sd_l1 <= SD_RST;
      r_sd_r0 <= SD_RST;
      r_sd_r1 <= SD_RST;
`endif
    end else if (r_state == ST_IDLE && bus.cpu_wr) begin
      case (bus.cpu_ch)
        2'd0:    r_sd_l0 <= bus.cpu_data;
        2'd1:    r_sd_l1 <= bus.cpu_data;
        2'd2:    r_sd_r0 <= bus.cpu_data;
        default: r_sd_r1 <= bus.cpu_data;
      endcase
    end else if (w_pop) begin
      r_sd_l0 <= w_head[31:24];
      r_sd_l1 <= w_head[23:16];
      r_sd_r0 <= w_head[15:8];
      r_sd_r1 <= w_head[7:0];
    end
  end

  // Set wins over clear so a same-cycle clear can never hide a fresh underrun.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)                r_underrun <= 1'b0;
    else if (w_urun)           r_underrun <= 1'b1;
    else if (bus.underrun_clr) r_underrun <= 1'b0;
  end

  assign bus.dma_ack    = w_push;
  assign bus.sd_l0      = r_sd_l0;
  assign bus.sd_l1      = r_sd_l1;
  assign bus.sd_r0      = r_sd_r0;
  assign bus.sd_r1      = r_sd_r1;
  assign bus.fifo_level = r_level;
  assign bus.underrun   = r_underrun;
endmodule

// File: tb/tb_soundrive_sched.sv
// Directed bench for soundrive_sched: CPU-write vector table, then priming, playback, backpressure
// and reset sequences, all with hand-computed expectations.
module tb_soundrive_sched;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 12;
`ifdef SOUNDRIVE_SCHED_MIDSCALE_EN
  localparam logic [7:0] SD_RST  = 8'h80;
  localparam bit         MIDSCALE = 1'b1;
`else
  localparam logic [7:0] SD_RST  = 8'h00;
  localparam bit         MIDSCALE = 1'b0;
`endif
  localparam logic [31:0] SD_RST4 = {4{SD_RST}};

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  soundrive_if #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) bus ();
  soundrive_sched #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk28 = ~clk28;

  typedef struct {
    logic        wr;
    logic [1:0]  ch;
    logic [7:0]  d;
    logic [31:0] exp_sd;
  } cpu_vec_t;

  cpu_vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clk();
    @(posedge clk28);
    #1;
  endtask

  function automatic logic [31:0] sd_all();
    return {bus.sd_l0, bus.sd_l1, bus.sd_r0, bus.sd_r1};
  endfunction

  function automatic logic [31:0] fa(input int k);
    return {8'hA0 + 8'(k), 8'hB0 + 8'(k), 8'hC0 + 8'(k), 8'hD0 + 8'(k)};
  endfunction

  function automatic logic [31:0] fb(input int k);
    return {8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3)};
  endfunction

  function automatic logic [31:0] fc(input int k);
    return 32'h1020_3040 + 32'(k);
  endfunction

  initial begin
    logic [31:0] saved;
    int          n_ack;
    bit          popped;

    bus.cpu_wr = 0; bus.cpu_ch = 0; bus.cpu_data = 0; bus.stream_en = 0;
    bus.rate_div = 0; bus.dma_req = 0; bus.dma_data = 0; bus.underrun_clr = 0;

    vt[0] = '{1'b1, 2'd2, 8'h5A, {SD_RST, SD_RST, 8'h5A, SD_RST}};
    vt[1] = '{1'b1, 2'd0, 8'h11, {8'h11, SD_RST, 8'h5A, SD_RST}};
    vt[2] = '{1'b1, 2'd3, 8'hC3, {8'h11, SD_RST, 8'h5A, 8'hC3}};
    vt[3] = '{1'b1, 2'd1, 8'h7E, {8'h11, 8'h7E, 8'h5A, 8'hC3}};
    vt[4] = '{1'b1, 2'd2, 8'hA5, {8'h11, 8'h7E, 8'hA5, 8'hC3}};
    vt[5] = '{1'b0, 2'd0, 8'hFF, {8'h11, 8'h7E, 8'hA5, 8'hC3}};

    #12;
    chk("rst_sd", sd_all(), SD_RST4);
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_underrun", 32'(bus.underrun), 0);
    bus.dma_req = 1; #1;
    chk("rst_ack", 32'(bus.dma_ack), 0);
    bus.dma_req = 0;
    #2 rst_n = 1;
    clk();

    // CPU mode table: stream_en=0, one strobe per entry
    for (int i = 0; i < 6; i++) begin
      bus.cpu_wr = vt[i].wr; bus.cpu_ch = vt[i].ch; bus.cpu_data = vt[i].d;
      clk();
      bus.cpu_wr = 0;
      chk($sformatf("cpu_vec%0d", i), sd_all(), vt[i].exp_sd);
    end
    bus.dma_req = 1; #1;
    chk("idle_no_ack", 32'(bus.dma_ack), 0);
    bus.dma_req = 0;

    // Priming, then first pop 10 cycles after entering PLAY with rate_div=9
    saved = sd_all();
    bus.stream_en = 1; bus.rate_div = 12'd9;
    clk();
    bus.dma_req = 1;
    for (int k = 0; k < 4; k++) begin
      bus.dma_data = fa(k); #1;
      chk($sformatf("prime_ack%0d", k), 32'(bus.dma_ack), 1);
      clk();
      if (k == 2) begin
        chk("prime_lvl3", 32'(bus.fifo_level), 3);
        chk("prime_sd_hold", sd_all(), saved);
      end
    end
    bus.dma_req = 0;
    clk();
    bus.cpu_wr = 1; bus.cpu_ch = 0; bus.cpu_data = 8'hFF;
    clk();
    bus.cpu_wr = 0;
    chk("play_cpu_drop", sd_all(), saved);
    for (int i = 0; i < 8; i++) clk();
    chk("play_no_pop_yet", sd_all(), saved);
    clk();
    chk("play_first_pop", sd_all(), fa(0));
    chk("play_lvl_after_pop", 32'(bus.fifo_level), 3);

    bus.stream_en = 0;
    clk();
    clk();
    chk("idle_flush", 32'(bus.fifo_level), 0);
    chk("idle_sd", sd_all(), MIDSCALE ? 32'h8080_8080 : fa(0));
    saved = MIDSCALE ? 32'h8080_8080 : fa(0);
    bus.cpu_wr = 1; bus.cpu_ch = 0; bus.cpu_data = 8'hFF;
    clk();
    bus.cpu_wr = 0;
    chk("idle_cpu_wr", sd_all(), {8'hFF, saved[23:0]});

    // rate_div=0: eight frames play out one per cycle, then underrun
    bus.rate_div = 12'd0; bus.stream_en = 1;
    clk();
    bus.dma_req = 1;
    for (int k = 1; k <= 8; k++) begin
      bus.dma_data = fb(k);
      clk();
      if (k >= 6) chk($sformatf("rate0_pop%0d", k - 5), sd_all(), fb(k - 5));
    end
    bus.dma_req = 0;
    for (int k = 4; k <= 8; k++) begin
      clk();
      chk($sformatf("rate0_pop%0d", k), sd_all(), fb(k));
    end
    chk("rate0_empty", 32'(bus.fifo_level), 0);
    chk("rate0_no_urun_yet", 32'(bus.underrun), 0);
    bus.underrun_clr = 1;
    clk();
    bus.underrun_clr = 0;
    chk("urun_set_prio", 32'(bus.underrun), 1);
    chk("urun_sd", sd_all(), MIDSCALE ? 32'h8080_8080 : fb(8));
    saved = sd_all();
    bus.underrun_clr = 1;
    clk();
    bus.underrun_clr = 0;
    chk("urun_clear", 32'(bus.underrun), 0);
    bus.dma_req = 1; bus.dma_data = fb(9); #1;
    chk("reprime_ack", 32'(bus.dma_ack), 1);
    clk();
    clk();
    chk("reprime_lvl", 32'(bus.fifo_level), 2);
    chk("reprime_sd_hold", sd_all(), saved);

    // Asynchronous reset mid-stream
    rst_n = 0; #1;
    chk("arst_level", 32'(bus.fifo_level), 0);
    chk("arst_sd", sd_all(), SD_RST4);
    chk("arst_ack", 32'(bus.dma_ack), 0);
    bus.dma_req = 0;
    #2 rst_n = 1;
    clk();

    // Backpressure: slowest rate, dma_req held
    bus.rate_div = 12'hFFF; bus.stream_en = 1; bus.dma_req = 1;
    n_ack = 0;
    for (int i = 0; i < 14; i++) begin
      bus.dma_data = fc(n_ack); #1;
      if (bus.dma_ack) n_ack++;
      clk();
    end
    chk("full_ack_count", 32'(n_ack), 8);
    chk("full_level", 32'(bus.fifo_level), 8);
    chk("full_no_ack", 32'(bus.dma_ack), 0);
    popped = 0;
    for (int i = 0; i < 5000 && !popped; i++) begin
      bus.dma_data = fc(n_ack);
      clk();
      if (bus.fifo_level == 7) popped = 1;
    end
    chk("full_pop_seen", 32'(popped), 1);
    chk("full_pop_sd", sd_all(), fc(0));
    #1;
    chk("full_ack_after_pop", 32'(bus.dma_ack), 1);
    clk();
    chk("full_refill", 32'(bus.fifo_level), 8);
    #1;
    chk("full_ack_again_off", 32'(bus.dma_ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
